// File: rtl/alici_pkg.sv
// Shared definitions for the alici receiver (and its verici transmitter peer).
package alici_pkg;

  // Width of one serial character in bits.
  localparam int KARAKTER_GENISLIK = 3;

  // Width of the character index counter (enough for 20 characters).
  localparam int SAYAC_GENISLIK = 5;

  // Width of the inter-character idle counter.
  localparam int BOSLUK_GENISLIK = 8;

  // Width of the completed-frame counter.
  localparam int CERCEVE_GENISLIK = 8;

  // Default word width, agreed with the verici transmitter.
  localparam int VARSAYILAN_N = 30;

  // Receiver states: idle, or collecting a serial frame.
  typedef enum logic [0:0] {
    BOS   = 1'b0,
    TOPLA = 1'b1
  } durum_e;

  // Number of serial characters that make up one word.
  function automatic int karakter_sayisi(input int genislik);
    return genislik / KARAKTER_GENISLIK;
  endfunction

endpackage

// File: rtl/alici_if.sv
// Bus between the verici transmitter side and the alici receiver.
interface alici_if #(
  parameter int N = alici_pkg::VARSAYILAN_N
) ();

  logic         mod;
  logic         gelen_gecerli;
  logic [N-1:0] gelen_veri;
  logic [N-1:0] cikan_veri;
  logic         bitti;
  logic         hata;
  logic [7:0]   cerceve_sayisi;

  modport master (
    output mod,
    output gelen_gecerli,
    output gelen_veri,
    input  cikan_veri,
    input  bitti,
    input  hata,
    input  cerceve_sayisi
  );

  modport slave (
    input  mod,
    input  gelen_gecerli,
    input  gelen_veri,
    output cikan_veri,
    output bitti,
    output hata,
    output cerceve_sayisi
  );

endinterface

// File: rtl/alici_bosluk_sayaci.sv
// Idle-cycle counter inside a serial frame; flags the cycle on which one
// more idle cycle would abort the frame. Wraps to zero when it expires.
module alici_bosluk_sayaci
  import alici_pkg::*;
#(
  parameter int ZAMAN_ASIMI = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic temizle,
  input  logic say,
  output logic doldu
);

  localparam logic [BOSLUK_GENISLIK-1:0] SON_DEGER = BOSLUK_GENISLIK'(ZAMAN_ASIMI - 1);

  logic [BOSLUK_GENISLIK-1:0] sayac_q;
  logic [BOSLUK_GENISLIK-1:0] sayac_d;

  assign doldu = (sayac_q == SON_DEGER);

  // Next idle count: clear has priority, expiry wraps back to zero.
  always_comb begin
    sayac_d = sayac_q;
    if (temizle) begin
      sayac_d = {BOSLUK_GENISLIK{1'b0}};
    end else if (say) begin
      sayac_d = doldu ? {BOSLUK_GENISLIK{1'b0}} : sayac_q + {{(BOSLUK_GENISLIK-1){1'b0}}, 1'b1};
    end else begin
      sayac_d = sayac_q;
    end
  end

  // Idle count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sayac_q <= {BOSLUK_GENISLIK{1'b0}};
    end else begin
      sayac_q <= sayac_d;
    end
  end

endmodule

// File: rtl/alici.sv
// alici: rebuilds N-bit words from a parallel word or a stream of 3-bit
// characters (most significant first), strobes bitti on completion, aborts
// stalled serial frames with hata and counts completed frames.
module alici
  import alici_pkg::*;
#(
  parameter int N           = VARSAYILAN_N,
  parameter int ZAMAN_ASIMI = 8
) (
  input  logic   clk,
  input  logic   rst,
  alici_if.slave bus
);

  localparam int KARAKTER_SAYISI = karakter_sayisi(N);
  localparam bit TEK_KARAKTER    = (KARAKTER_SAYISI == 1);
  localparam logic [SAYAC_GENISLIK-1:0] SON_INDIS    = SAYAC_GENISLIK'(KARAKTER_SAYISI - 1);
  // Only meaningful for multi-character words; unused when N == 3.
  localparam logic [SAYAC_GENISLIK-1:0] IKINCI_INDIS = SAYAC_GENISLIK'(KARAKTER_SAYISI - 2);

  durum_e                      durum_q;
  durum_e                      durum_d;
  logic [SAYAC_GENISLIK-1:0]   sayac_q;
  logic [SAYAC_GENISLIK-1:0]   sayac_d;
  logic [N-1:0]                tampon_q;
  logic [N-1:0]                tampon_d;
  logic [N-1:0]                cikan_q;
  logic [N-1:0]                cikan_d;
  logic                        bitti_q;
  logic                        bitti_d;
  logic                        hata_q;
  logic                        hata_d;
  logic [CERCEVE_GENISLIK-1:0] cerceve_q;
  logic [CERCEVE_GENISLIK-1:0] cerceve_d;

  logic [KARAKTER_GENISLIK-1:0] karakter;
  logic                         bosluk_temizle;
  logic                         bosluk_say;
  logic                         bosluk_doldu;

  // In serial mode only the low character bits carry data.
  assign karakter = bus.gelen_veri[KARAKTER_GENISLIK-1:0];

  // Idle cycles are only counted while collecting; any valid input or idle state clears.
  assign bosluk_temizle = (durum_q == BOS) || bus.gelen_gecerli;
  assign bosluk_say     = (durum_q == TOPLA) && !bus.gelen_gecerli;

  alici_bosluk_sayaci #(
    .ZAMAN_ASIMI(ZAMAN_ASIMI)
  ) u_bosluk (
    .clk    (clk),
    .rst    (rst),
    .temizle(bosluk_temizle),
    .say    (bosluk_say),
    .doldu  (bosluk_doldu)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      durum_q <= BOS;
    end else begin
      durum_q <= durum_d;
    end
  end

  // Next state: enter TOPLA on a multi-character serial start, leave on the last character or timeout.
  always_comb begin
    durum_d = durum_q;
    case (durum_q)
      BOS: begin
        if (bus.gelen_gecerli && bus.mod && !TEK_KARAKTER) begin
          durum_d = TOPLA;
        end else begin
          durum_d = BOS;
        end
      end
      TOPLA: begin
        if (bus.gelen_gecerli) begin
          durum_d = (sayac_q == {SAYAC_GENISLIK{1'b0}}) ? BOS : TOPLA;
        end else if (bosluk_doldu) begin
          durum_d = BOS;
        end else begin
          durum_d = TOPLA;
        end
      end
      default: durum_d = BOS;
    endcase
  end

  // Datapath and output next values: buffer fill, word completion, timeout pulse, frame count.
  always_comb begin
    sayac_d   = sayac_q;
    tampon_d  = tampon_q;
    cikan_d   = cikan_q;
    bitti_d   = 1'b0;
    hata_d    = 1'b0;
    cerceve_d = cerceve_q;
    case (durum_q)
      BOS: begin
        if (bus.gelen_gecerli) begin
          if (!bus.mod) begin
            cikan_d   = bus.gelen_veri;
            bitti_d   = 1'b1;
            cerceve_d = cerceve_q + 8'd1;
          end else begin
            tampon_d[N-1 -: KARAKTER_GENISLIK] = karakter;
            if (TEK_KARAKTER) begin
              cikan_d   = tampon_d;
              bitti_d   = 1'b1;
              cerceve_d = cerceve_q + 8'd1;
              sayac_d   = SON_INDIS;
            end else begin
              sayac_d = IKINCI_INDIS;
            end
          end
        end else begin
          sayac_d = sayac_q;
        end
      end
      TOPLA: begin
        if (bus.gelen_gecerli) begin
          for (int i = 0; i < KARAKTER_SAYISI; i++) begin
            tampon_d[i*KARAKTER_GENISLIK +: KARAKTER_GENISLIK] =
              (sayac_q == SAYAC_GENISLIK'(i)) ? karakter
                                              : tampon_q[i*KARAKTER_GENISLIK +: KARAKTER_GENISLIK];
          end
          if (sayac_q == {SAYAC_GENISLIK{1'b0}}) begin
            cikan_d   = tampon_d;
            bitti_d   = 1'b1;
            cerceve_d = cerceve_q + 8'd1;
            sayac_d   = SON_INDIS;
          end else begin
            sayac_d = sayac_q - {{(SAYAC_GENISLIK-1){1'b0}}, 1'b1};
          end
        end else if (bosluk_doldu) begin
          hata_d  = 1'b1;
          sayac_d = SON_INDIS;
        end else begin
          sayac_d = sayac_q;
        end
      end
      default: begin
        sayac_d = SON_INDIS;
      end
    endcase
  end

  // Datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sayac_q   <= SON_INDIS;
      tampon_q  <= {N{1'b0}};
      cikan_q   <= {N{1'b0}};
      bitti_q   <= 1'b0;
      hata_q    <= 1'b0;
      cerceve_q <= {CERCEVE_GENISLIK{1'b0}};
    end else begin
      sayac_q   <= sayac_d;
      tampon_q  <= tampon_d;
      cikan_q   <= cikan_d;
      bitti_q   <= bitti_d;
      hata_q    <= hata_d;
      cerceve_q <= cerceve_d;
    end
  end

  assign bus.cikan_veri     = cikan_q;
  assign bus.bitti          = bitti_q;
  assign bus.hata           = hata_q;
  assign bus.cerceve_sayisi = cerceve_q;

endmodule

// File: tb/tb_alici.sv
// Self-checking bench for alici: vector table, hand-written corner sequences
// and randomized traffic against a word-accumulating reference model.
module tb_alici;

  localparam int N  = 30;
  localparam int ZA = 8;
  localparam int NK = N / 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alici_if #(.N(N)) bus ();

  alici #(.N(N), .ZAMAN_ASIMI(ZA)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_gecen  = 0;
  int n_toplam = 0;

  // reference model state
  logic [N-1:0] m_out;
  logic         m_bitti;
  logic         m_hata;
  int           m_cnt;
  bit           m_in;
  longint       m_acc;
  int           m_nchar;
  int           m_idle;

  typedef struct {
    logic         r;
    logic         m;
    logic         v;
    logic [N-1:0] veri;
    logic [N-1:0] e_out;
    logic         e_b;
    logic         e_h;
    logic [7:0]   e_c;
  } vektor_t;

  vektor_t tbl [16];

  task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
    n_toplam++;
    if (gercek === beklenen) n_gecen++;
    else $display("FAIL %s: got %0h, expected %0h", ad, gercek, beklenen);
  endtask

  task automatic hepsi(input string ad, input logic [N-1:0] eo, input logic eb, input logic eh,
                       input logic [7:0] ec);
    kontrol({ad, "_veri"},  64'(bus.cikan_veri), 64'(eo));
    kontrol({ad, "_bitti"}, 64'(bus.bitti), 64'(eb));
    kontrol({ad, "_hata"},  64'(bus.hata), 64'(eh));
    kontrol({ad, "_sayi"},  64'(bus.cerceve_sayisi), 64'(ec));
  endtask

  task automatic model_kontrol(input string ad);
    hepsi(ad, m_out, m_bitti, m_hata, 8'(m_cnt));
  endtask

  // Drive one cycle of inputs and advance the model to what should be visible after the edge.
  task automatic surt(input logic r, input logic m, input logic v, input logic [N-1:0] d);
    rst = r;
    bus.mod = m;
    bus.gelen_gecerli = v;
    bus.gelen_veri = d;
    m_bitti = 1'b0;
    m_hata  = 1'b0;
    if (r) begin
      m_out = '0; m_cnt = 0; m_in = 0; m_acc = 0; m_nchar = 0; m_idle = 0;
    end else if (!m_in) begin
      if (v) begin
        if (!m) begin
          m_out = d; m_bitti = 1'b1; m_cnt = (m_cnt + 1) % 256;
        end else begin
          m_acc = longint'(d[2:0]); m_nchar = 1; m_idle = 0; m_in = 1;
        end
      end
    end else if (v) begin
      m_acc = m_acc * 8 + longint'(d[2:0]);
      m_nchar++;
      m_idle = 0;
      if (m_nchar == NK) begin
        m_out = N'(m_acc); m_bitti = 1'b1; m_cnt = (m_cnt + 1) % 256; m_in = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == ZA) begin
        m_hata = 1'b1; m_in = 0; m_idle = 0;
      end
    end
  endtask

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  // Character k (0 = least significant) of a word, with the other chars as upper-bit noise.
  function automatic logic [N-1:0] kar(input logic [N-1:0] w, input int k);
    return w >> (3 * k);
  endfunction

  task automatic cerceve_gonder(input string ad, input logic [N-1:0] w);
    for (int k = NK - 1; k >= 0; k--) begin
      surt(1'b0, 1'b1, 1'b1, kar(w, k));
      adim();
      model_kontrol(ad);
    end
  endtask

  initial begin
    logic [N-1:0] w;
    int bitti_say;
    int quiet;
    bit sarma_goruldu;
    logic [7:0] onceki;

    rst = 1'b1;
    bus.mod = 1'b0;
    bus.gelen_gecerli = 1'b0;
    bus.gelen_veri = '0;
    m_out = '0; m_bitti = 1'b0; m_hata = 1'b0; m_cnt = 0;
    m_in = 0; m_acc = 0; m_nchar = 0; m_idle = 0;

    // vector table
    tbl[0] = '{1'b1, 1'b0, 1'b0, 30'h0, 30'h0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 30'h1234_5678, 30'h1234_5678, 1'b1, 1'b0, 8'd1};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 30'h0, 30'h1234_5678, 1'b0, 1'b0, 8'd1};
    for (int i = 0; i < 10; i++) begin
      tbl[3 + i] = '{1'b0, 1'b1, 1'b1, {27'h5A5_A5A5 + 27'(i), 3'(i % 8)},
                     (i < 9) ? 30'h1234_5678 : 30'o0123456701,
                     (i == 9), 1'b0, (i < 9) ? 8'd1 : 8'd2};
    end
    tbl[13] = '{1'b0, 1'b0, 1'b0, 30'h0, 30'o0123456701, 1'b0, 1'b0, 8'd2};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 30'h2AAA_AAAA, 30'h2AAA_AAAA, 1'b1, 1'b0, 8'd3};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 30'h3FFF_FFFF, 30'h2AAA_AAAA, 1'b0, 1'b0, 8'd3};

    for (int i = 0; i < 16; i++) begin
      surt(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].veri);
      adim();
      hepsi($sformatf("tbl%0d", i), tbl[i].e_out, tbl[i].e_b, tbl[i].e_h, tbl[i].e_c);
    end

    // serial frame with a 3-cycle gap after char 4 and mod dropped mid-frame
    w = 30'o0123456701;
    for (int k = NK - 1; k >= 0; k--) begin
      if (k == 4) begin
        for (int g = 0; g < 3; g++) begin
          surt(1'b0, 1'b0, 1'b0, 30'h0);
          adim();
          model_kontrol("bosluk");
        end
      end
      surt(1'b0, (k >= 5) ? 1'b1 : 1'b0, 1'b1, kar(w, k));
      adim();
      model_kontrol("bosluk");
    end
    kontrol("bosluk_sonuc", 64'(bus.cikan_veri), 64'(30'o0123456701));
    kontrol("bosluk_bitti", 64'(bus.bitti), 64'd1);

    // timeout: 4 chars then 8 idle cycles
    w = 30'o7654321076;
    for (int k = NK - 1; k >= NK - 4; k--) begin
      surt(1'b0, 1'b1, 1'b1, kar(w, k));
      adim();
      model_kontrol("zaman");
    end
    for (int g = 1; g <= ZA; g++) begin
      surt(1'b0, 1'b1, 1'b0, 30'h0);
      adim();
      model_kontrol("zaman_bos");
      if (g == ZA - 1) kontrol("zaman_erken", 64'(bus.hata), 64'd0);
    end
    kontrol("zaman_hata", 64'(bus.hata), 64'd1);
    kontrol("zaman_veri", 64'(bus.cikan_veri), 64'(30'o0123456701));
    surt(1'b0, 1'b0, 1'b0, 30'h0);
    adim();
    kontrol("zaman_tek", 64'(bus.hata), 64'd0);
    cerceve_gonder("zaman_yeni", w);
    kontrol("zaman_yeni_veri", 64'(bus.cikan_veri), 64'(30'o7654321076));

    // valid char on the very cycle the timeout would fire
    w = 30'o1357024613;
    for (int k = NK - 1; k >= NK - 2; k--) begin
      surt(1'b0, 1'b1, 1'b1, kar(w, k));
      adim();
      model_kontrol("sinir");
    end
    for (int g = 0; g < ZA - 1; g++) begin
      surt(1'b0, 1'b1, 1'b0, 30'h0);
      adim();
      model_kontrol("sinir_bos");
    end
    for (int k = NK - 3; k >= 0; k--) begin
      surt(1'b0, 1'b1, 1'b1, kar(w, k));
      adim();
      model_kontrol("sinir");
      if (k == NK - 3) kontrol("sinir_hata_yok", 64'(bus.hata), 64'd0);
    end
    kontrol("sinir_veri", 64'(bus.cikan_veri), 64'(30'o1357024613));

    // reset mid-frame
    for (int k = NK - 1; k >= NK - 5; k--) begin
      surt(1'b0, 1'b1, 1'b1, kar(w, k));
      adim();
      model_kontrol("rst_on");
    end
    surt(1'b1, 1'b1, 1'b0, 30'h0);
    adim();
    hepsi("rst_ara", 30'h0, 1'b0, 1'b0, 8'd0);
    surt(1'b0, 1'b0, 1'b1, 30'h3FFF_FFFF);
    adim();
    hepsi("rst_sonra", 30'h3FFF_FFFF, 1'b1, 1'b0, 8'd1);

    // 256 back-to-back parallel words
    bitti_say = 0;
    sarma_goruldu = 0;
    for (int i = 0; i < 256; i++) begin
      onceki = bus.cerceve_sayisi;
      surt(1'b0, 1'b0, 1'b1, N'($urandom));
      adim();
      model_kontrol("arka");
      if (bus.bitti === 1'b1) bitti_say++;
      if (onceki == 8'd255 && bus.cerceve_sayisi == 8'd0) sarma_goruldu = 1;
    end
    kontrol("arka_bitti_say", 64'(bitti_say), 64'd256);
    kontrol("arka_sarma", 64'(sarma_goruldu), 64'd1);
    kontrol("arka_son_sayi", 64'(bus.cerceve_sayisi), 64'd1);

    // randomized traffic
    quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      logic v;
      if (quiet > 0) begin
        v = 1'b0;
        quiet--;
      end else begin
        v = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 19) == 0) quiet = $urandom_range(5, 12);
      end
      surt(($urandom_range(0, 299) == 0), 1'($urandom), v, N'($urandom));
      adim();
      model_kontrol("rastgele");
      if (bus.bitti === 1'b1 && bus.hata === 1'b1) kontrol("rastgele_ikisi", 64'd1, 64'd0);
    end

    $display("%0d/%0d checks passed", n_gecen, n_toplam);
    $finish;
  end

endmodule
